// File: rtl/sparc_regfile_pkg.sv
// Shared constants and types for the windowed integer register file.
package sparc_regfile_pkg;

    // Window geometry
    localparam int NWINDOWS      = 8;
    localparam int CWP_BITS      = $clog2(NWINDOWS);
    localparam int PHYS_BITS     = 8;
    localparam int GLOBAL_REGS   = 8;
    localparam int WINDOW_STRIDE = 16;

    // Outcome of the window request handled in a given cycle
    typedef enum logic [2:0] {
        NONE = 3'd0,
        DONE = 3'd1,
        OVF  = 3'd2,
        UNF  = 3'd3,
        ERR  = 3'd4
    } win_result_e;

endpackage

// File: rtl/reg_window_map.sv
// Logical-to-physical register index translation for one register-file port.
// Globals pass straight through; windowed registers are offset by cwp*16 and
// wrap inside the windowed region, so a window's ins alias the next window's outs.
module reg_window_map #(
    parameter int OpCode_bits = 5,
    parameter int CWP_BITS    = sparc_regfile_pkg::CWP_BITS,
    parameter int PHYS_BITS   = sparc_regfile_pkg::PHYS_BITS
) (
    input  logic [CWP_BITS-1:0]    cwp,
    input  logic [OpCode_bits-1:0] r,
    output logic [PHYS_BITS-1:0]   phys
);

    localparam int STRIDE_BITS = $clog2(sparc_regfile_pkg::WINDOW_STRIDE);
    localparam int OFF_BITS    = CWP_BITS + STRIDE_BITS;

    logic [OFF_BITS-1:0] win_base;
    logic [OFF_BITS-1:0] win_off;
    logic [OFF_BITS-1:0] off;

    // Offset width is exactly log2(16*NWINDOWS), so the sum wraps modulo the windowed region
    always_comb begin
        win_base = {cwp, {STRIDE_BITS{1'b0}}};
        win_off  = OFF_BITS'(r) - OFF_BITS'(sparc_regfile_pkg::GLOBAL_REGS);
        off      = win_base + win_off;
        if (r < OpCode_bits'(sparc_regfile_pkg::GLOBAL_REGS)) begin
            phys = PHYS_BITS'(r);
        end else begin
            phys = PHYS_BITS'(sparc_regfile_pkg::GLOBAL_REGS) + PHYS_BITS'(off);
        end
    end

endmodule

// File: rtl/reg_window_ctrl.sv
// Register-window controller: owns CWP and WIM, sequences SAVE/RESTORE,
// trap entry and explicit CWP/WIM writes, flags overflow/underflow, and maps
// the three logical register operands onto physical register-file indices.
module reg_window_ctrl #(
    parameter int NWINDOWS    = sparc_regfile_pkg::NWINDOWS,
    parameter int OpCode_bits = 5,
    parameter int CWP_BITS    = sparc_regfile_pkg::CWP_BITS,
    parameter int PHYS_BITS   = sparc_regfile_pkg::PHYS_BITS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   save,
    input  logic                   restore,
    input  logic                   trap_enter,
    input  logic                   wr_cwp_en,
    input  logic [CWP_BITS-1:0]    wr_cwp_data,
    input  logic                   wr_wim_en,
    input  logic [NWINDOWS-1:0]    wr_wim_data,
    input  logic [OpCode_bits-1:0] rs1,
    input  logic [OpCode_bits-1:0] rs2,
    input  logic [OpCode_bits-1:0] rd,
    output logic [CWP_BITS-1:0]    cwp,
    output logic [NWINDOWS-1:0]    wim,
    output logic [PHYS_BITS-1:0]   phys_rs1,
    output logic [PHYS_BITS-1:0]   phys_rs2,
    output logic [PHYS_BITS-1:0]   phys_rd,
    output logic                   win_done,
    output logic                   win_ovf,
    output logic                   win_unf,
    output logic                   seq_err
);

    logic [CWP_BITS-1:0] cwp_q;
    logic [CWP_BITS-1:0] cwp_nxt;
    logic [CWP_BITS-1:0] cwp_dec;
    logic [CWP_BITS-1:0] cwp_inc;
    logic [NWINDOWS-1:0] wim_q;
    logic [NWINDOWS-1:0] wim_nxt;

    sparc_regfile_pkg::win_result_e res_q;
    sparc_regfile_pkg::win_result_e res_nxt;

    // State register: CWP, WIM and the result code of the last request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cwp_q <= '0;
            wim_q <= '0;
            res_q <= sparc_regfile_pkg::NONE;
        end else begin
            cwp_q <= cwp_nxt;
            wim_q <= wim_nxt;
            res_q <= res_nxt;
        end
    end

    // Next-state: request priority trap > CWP write > save/restore; checks use pre-write WIM
    always_comb begin
        cwp_dec = cwp_q - CWP_BITS'(1);
        cwp_inc = cwp_q + CWP_BITS'(1);
        cwp_nxt = cwp_q;
        res_nxt = sparc_regfile_pkg::NONE;
        wim_nxt = wr_wim_en ? wr_wim_data : wim_q;

        if (trap_enter) begin
            cwp_nxt = cwp_dec;
        end else if (wr_cwp_en) begin
            cwp_nxt = wr_cwp_data;
        end else if (save && restore) begin
            res_nxt = sparc_regfile_pkg::ERR;
        end else if (save) begin
            if (wim_q[cwp_dec]) begin
                res_nxt = sparc_regfile_pkg::OVF;
            end else begin
                cwp_nxt = cwp_dec;
                res_nxt = sparc_regfile_pkg::DONE;
            end
        end else if (restore) begin
            if (wim_q[cwp_inc]) begin
                res_nxt = sparc_regfile_pkg::UNF;
            end else begin
                cwp_nxt = cwp_inc;
                res_nxt = sparc_regfile_pkg::DONE;
            end
        end
    end

    // Outputs: decode the registered result code into one-hot single-cycle pulses
    always_comb begin
        cwp      = cwp_q;
        wim      = wim_q;
        win_done = (res_q == sparc_regfile_pkg::DONE);
        win_ovf  = (res_q == sparc_regfile_pkg::OVF);
        win_unf  = (res_q == sparc_regfile_pkg::UNF);
        seq_err  = (res_q == sparc_regfile_pkg::ERR);
    end

    reg_window_map #(
        .OpCode_bits (OpCode_bits),
        .CWP_BITS    (CWP_BITS),
        .PHYS_BITS   (PHYS_BITS)
    ) u_map_rs1 (
        .cwp  (cwp_q),
        .r    (rs1),
        .phys (phys_rs1)
    );

    reg_window_map #(
        .OpCode_bits (OpCode_bits),
        .CWP_BITS    (CWP_BITS),
        .PHYS_BITS   (PHYS_BITS)
    ) u_map_rs2 (
        .cwp  (cwp_q),
        .r    (rs2),
        .phys (phys_rs2)
    );

    reg_window_map #(
        .OpCode_bits (OpCode_bits),
        .CWP_BITS    (CWP_BITS),
        .PHYS_BITS   (PHYS_BITS)
    ) u_map_rd (
        .cwp  (cwp_q),
        .r    (rd),
        .phys (phys_rd)
    );

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Directed-vector bench for reg_window_ctrl (NWINDOWS = 8).
module tb_reg_window_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       save;
    logic       restore;
    logic       trap_enter;
    logic       wr_cwp_en;
    logic [2:0] wr_cwp_data;
    logic       wr_wim_en;
    logic [7:0] wr_wim_data;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] cwp;
    logic [7:0] wim;
    logic [7:0] phys_rs1;
    logic [7:0] phys_rs2;
    logic [7:0] phys_rd;
    logic       win_done;
    logic       win_ovf;
    logic       win_unf;
    logic       seq_err;

    logic [3:0] pv;
    int unsigned nvec  = 0;
    int unsigned nmiss = 0;

    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_DONE = 4'b1000;
    localparam logic [3:0] P_OVF  = 4'b0100;
    localparam logic [3:0] P_UNF  = 4'b0010;
    localparam logic [3:0] P_ERR  = 4'b0001;

    assign pv = {win_done, win_ovf, win_unf, seq_err};

    always #5 clk = ~clk;

    reg_window_ctrl #(
        .NWINDOWS    (8),
        .OpCode_bits (5),
        .CWP_BITS    (3),
        .PHYS_BITS   (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .save        (save),
        .restore     (restore),
        .trap_enter  (trap_enter),
        .wr_cwp_en   (wr_cwp_en),
        .wr_cwp_data (wr_cwp_data),
        .wr_wim_en   (wr_wim_en),
        .wr_wim_data (wr_wim_data),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .cwp         (cwp),
        .wim         (wim),
        .phys_rs1    (phys_rs1),
        .phys_rs2    (phys_rs2),
        .phys_rd     (phys_rd),
        .win_done    (win_done),
        .win_ovf     (win_ovf),
        .win_unf     (win_unf),
        .seq_err     (seq_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        save        = 1'b0;
        restore     = 1'b0;
        trap_enter  = 1'b0;
        wr_cwp_en   = 1'b0;
        wr_wim_en   = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        idle();
        wr_cwp_data = '0;
        wr_wim_data = '0;
        rs1 = 5'd8;
        rs2 = 5'd31;
        rd  = 5'd5;
        @(negedge clk);

        // Reset, with a save request discarded in the reset cycle
        save = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        save    = 1'b0;
        tick();
        check("rst_cwp", cwp, 0);
        check("rst_wim", wim, 8'h00);
        check("rst_pulses", pv, P_NONE);
        check("rst_phys_rs1", phys_rs1, 8);
        check("rst_phys_rs2", phys_rs2, 31);
        check("rst_phys_rd", phys_rd, 5);

        // SAVE from window 0 wraps to 7; old r8 aliases new r24
        save = 1'b1;
        tick();
        save = 1'b0;
        rs1 = 5'd24;
        rs2 = 5'd8;
        rd  = 5'd31;
        #1;
        check("save_done", pv, P_DONE);
        check("save_cwp", cwp, 7);
        check("alias_r24", phys_rs1, 8);
        check("map_r8_w7", phys_rs2, 120);
        check("map_r31_w7", phys_rd, 15);
        tick();
        check("save_pulse_1cyc", pv, P_NONE);

        // Overflow: wim bit 6 set blocks SAVE from window 7
        wr_wim_en = 1'b1; wr_wim_data = 8'h40;
        tick();
        wr_wim_en = 1'b0;
        check("wim_write", wim, 8'h40);
        save = 1'b1;
        tick();
        save = 1'b0;
        check("ovf_pulse", pv, P_OVF);
        check("ovf_cwp", cwp, 7);
        tick();
        check("ovf_pulse_1cyc", pv, P_NONE);

        // Underflow: wim bit 0 set blocks RESTORE from window 7
        wr_wim_en = 1'b1; wr_wim_data = 8'h01;
        tick();
        wr_wim_en = 1'b0;
        restore = 1'b1;
        tick();
        restore = 1'b0;
        check("unf_pulse", pv, P_UNF);
        check("unf_cwp", cwp, 7);

        // Trap beats CWP write and save; no pulse
        wr_cwp_en = 1'b1; wr_cwp_data = 3'd3;
        tick();
        check("wrcwp_cwp", cwp, 3);
        check("wrcwp_pulses", pv, P_NONE);
        trap_enter = 1'b1; save = 1'b1; wr_cwp_en = 1'b1; wr_cwp_data = 3'd5;
        tick();
        idle();
        check("trap_cwp", cwp, 2);
        check("trap_pulses", pv, P_NONE);

        // Simultaneous save and restore
        save = 1'b1; restore = 1'b1;
        tick();
        idle();
        check("seqerr_pulse", pv, P_ERR);
        check("seqerr_cwp", cwp, 2);

        // Save with concurrent WIM write uses the pre-write mask
        wr_wim_en = 1'b1; wr_wim_data = 8'h00;
        tick();
        save = 1'b1; wr_wim_en = 1'b1; wr_wim_data = 8'h02;
        tick();
        idle();
        check("prewim_done", pv, P_DONE);
        check("prewim_cwp", cwp, 1);
        check("prewim_wim", wim, 8'h02);
        wr_wim_en = 1'b1; wr_wim_data = 8'h01;
        tick();
        wr_wim_en = 1'b0;
        save = 1'b1;
        tick();
        save = 1'b0;
        check("ovf2_pulse", pv, P_OVF);
        check("ovf2_cwp", cwp, 1);

        // Reset with pending save clears state
        reset_n = 1'b0; save = 1'b1;
        tick();
        check("rst2_cwp", cwp, 0);
        check("rst2_wim", wim, 8'h00);
        check("rst2_pulses", pv, P_NONE);
        reset_n = 1'b1; save = 1'b0;
        tick();
        check("rst2_rel_cwp", cwp, 0);
        check("rst2_rel_pulses", pv, P_NONE);

        // Eight back-to-back restores walk 1..7 then wrap to 0
        rd = 5'd24;
        restore = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("rest%0d_cwp", i), cwp, i % 8);
            check($sformatf("rest%0d_done", i), pv, P_DONE);
            check($sformatf("rest%0d_phys_rd", i), phys_rd, 8 + (((i % 8) * 16 + 16) % 128));
        end
        restore = 1'b0;
        tick();
        check("rest_end_pulses", pv, P_NONE);
        check("rest_end_cwp", cwp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule

// File: doc/reg_window_ctrl.md
Name: reg_window_ctrl

Overview:
Register-window controller for the integer register file. It owns the Current Window Pointer (CWP) and Window Invalid Mask (WIM), and sequences SAVE, RESTORE, trap entry and explicit CWP/WIM writes. It detects window overflow and underflow. It translates 5-bit logical register numbers (r0..r31) into physical register indices, which drive the selects of the register-file read-port multiplexers (two read ports) and the write decoder (one write port).

Parameters:
NWINDOWS, 8, number of register windows (power of 2, 2..32)
OpCode_bits, 5, logical register number width
CWP_BITS, 3, log2(NWINDOWS)
PHYS_BITS, 8, physical index width, sized to hold 8 + 16*NWINDOWS - 1

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
save  in  1  SAVE request, single-cycle pulse
restore  in  1  RESTORE request, single-cycle pulse
trap_enter  in  1  trap entry, unconditional CWP decrement
wr_cwp_en  in  1  explicit CWP write (WRPSR)
wr_cwp_data  in  CWP_BITS  new CWP value
wr_wim_en  in  1  WIM write (WRWIM)
wr_wim_data  in  NWINDOWS  new WIM value
rs1  in  OpCode_bits  logical read-port-A register
rs2  in  OpCode_bits  logical read-port-B register
rd  in  OpCode_bits  logical write-port register
cwp  out  CWP_BITS  current window pointer
wim  out  NWINDOWS  current window invalid mask
phys_rs1  out  PHYS_BITS  physical index for read port A
phys_rs2  out  PHYS_BITS  physical index for read port B
phys_rd  out  PHYS_BITS  physical index for write port
win_done  out  1  pulse: SAVE/RESTORE completed
win_ovf  out  1  pulse: window overflow trap
win_unf  out  1  pulse: window underflow trap
seq_err  out  1  pulse: illegal simultaneous SAVE and RESTORE

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - cwp = 0, wim = 0.
  - win_done, win_ovf, win_unf and seq_err = 0.
  - Reset has priority over every request. Any request asserted in the reset cycle is discarded.
- Request priority, evaluated each cycle: trap_enter > wr_cwp_en > {save, restore}.
  - trap_enter: cwp <= (cwp - 1) mod NWINDOWS. No WIM check. Any save, restore or wr_cwp request in the same cycle is dropped, and no pulse is raised for it.
  - wr_cwp_en (no trap_enter): cwp <= wr_cwp_data. No WIM check. Any save or restore in the same cycle is dropped.
  - save only: target = (cwp - 1) mod NWINDOWS.
    - If wim[target] = 1: cwp unchanged and win_ovf = 1 in the next cycle.
    - Otherwise: cwp <= target and win_done = 1 in the next cycle.
  - restore only: target = (cwp + 1) mod NWINDOWS.
    - If wim[target] = 1: cwp unchanged and win_unf = 1.
    - Otherwise: cwp <= target and win_done = 1.
  - save and restore together: cwp unchanged and seq_err = 1 in the next cycle.
- WIM:
  - wr_wim_en: wim <= wr_wim_data, independent of the CWP path.
  - A WIM write in the same cycle as a save or restore does not affect that cycle's check. The check uses the pre-write WIM.
- Pulse outputs:
  - Registered; high for exactly one cycle, in the cycle after the request.
  - Mutually exclusive.
  - Back-to-back requests each produce their own pulse.
  - The cwp output reflects the new value in the same cycle as the pulse (latency 1).
- Wrap-around: modulo arithmetic on CWP_BITS. SAVE at cwp = 0 gives NWINDOWS - 1; RESTORE at NWINDOWS - 1 gives 0.
- Address mapping: combinational from the current cwp register, not from the next-state value. Applied identically to rs1, rs2 and rd.
  - r0..r7 (globals): phys = r.
  - r8..r31: phys = 8 + ((cwp*16 + (r - 8)) mod (16*NWINDOWS)).
  - As a result, the ins (r24..r31) of window w alias the outs (r8..r15) of window w+1 (mod NWINDOWS).
  - Physical r0 is read as index 0. Zero-forcing of r0 is the register file's responsibility, not this block's.

Decomposition:
- Shared package `sparc_regfile_pkg`:
  - Constants NWINDOWS, CWP_BITS, PHYS_BITS, GLOBAL_REGS = 8, WINDOW_STRIDE = 16.
  - Enum for the window result code: NONE, DONE, OVF, UNF, ERR.
- One sub-module `reg_window_map`: purely combinational logical-to-physical translation with inputs (cwp, r) and output phys.
  - Instantiated three times, for rs1, rs2 and rd.
  - The parent holds all sequential state and the priority logic.

Test Plan (all with NWINDOWS = 8):
- Reset, then rs1 = 8, rs2 = 31, rd = 5 -> cwp = 0, wim = 0x00, phys_rs1 = 8, phys_rs2 = 31, phys_rd = 5, no pulses.
- From cwp = 0, wim = 0, pulse save -> next cycle win_done = 1 and cwp = 7. With rs1 = 24: phys_rs1 = 8, i.e. the old r8 aliases the new r24.
- Set wim = 0x40, cwp = 7, pulse save -> win_ovf = 1 for one cycle and cwp stays 7. Then wim = 0x01, pulse restore -> win_unf = 1 and cwp stays 7.
- cwp = 3, assert trap_enter, save and wr_cwp_en (data = 5) in one cycle -> cwp = 2, no pulses. Next cycle assert save and restore together -> seq_err = 1, cwp stays 2.
- cwp = 2, wim = 0x00. In one cycle pulse save and write wim = 0x02 -> win_done = 1 and cwp = 1, because the pre-write WIM is used. A following save then gives win_ovf (target 0, with wim now 0x02 the bit-0 check passes, so use wim = 0x01 to force win_ovf).
- Pulse save while reset_n = 0 -> after reset release cwp = 0, no pulses. Then 8 consecutive restores with wim = 0 -> cwp sequence 1, 2, ..., 7, 0, with win_done on every cycle.
